line_memory: RTL

LINE_MEMORY -- requirements
Module: line_memory

---
 rtl/line_memory_pkg.sv | 16 +
 rtl/line_memory_if.sv | 30 +++
 rtl/line_mem_array.sv | 34 +++
 rtl/line_memory.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/line_memory_pkg.sv
// line_memory shared package: bus geometry and the control FSM state encoding.
package line_memory_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int FETCH_SIZE     = 64;
    localparam int WORDS_PER_LINE = FETCH_SIZE / WORD_SIZE;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_WAIT    = 3'd1,
        RD_DRIVE   = 3'd2,
        WR_WAIT    = 3'd3,
        WR_CAPTURE = 3'd4
    } lineMemState_t;

endpackage

// File: rtl/line_memory_if.sv
// line_memory request/status interface. The 64-bit tristate line bus dataM
// stays a plain inout port on the block so tristate resolution is direct.
// Optional statistics outputs appear only when LINE_MEM_STATS_EN is defined.
//
// Handshake: there is no ready signal. readM/writeM are single-cycle request
// strobes sampled on a rising edge; a request is accepted only when the block
// is idle (busy low) and exactly one strobe is high. A strobe seen while busy,
// or both strobes together, is dropped and raises the sticky err flag.
interface line_memory_if;
    logic        readM;
    logic        writeM;
    logic [15:0] addressM;
    logic        busy;
    logic        err;
`ifdef LINE_MEM_STATS_EN
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    logic [15:0] err_cnt;

    modport master (output readM, writeM, addressM,
                    input  busy, err, rd_cnt, wr_cnt, err_cnt);
    modport slave  (input  readM, writeM, addressM,
                    output busy, err, rd_cnt, wr_cnt, err_cnt);
`else
    modport master (output readM, writeM, addressM,
                    input  busy, err);
    modport slave  (input  readM, writeM, addressM,
                    output busy, err);
`endif
endinterface

// File: rtl/line_mem_array.sv
// Line-organised storage: one synchronous 64-bit line write port and one
// asynchronous 64-bit line read port. Reset clears every line to zero.
module line_mem_array
    import line_memory_pkg::*;
#(
    parameter int LINE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [LINE_W-1:0]     wrIdx,
    input  logic [FETCH_SIZE-1:0] wrData,
    input  logic [LINE_W-1:0]     rdIdx,
    output logic [FETCH_SIZE-1:0] rdData
);

    localparam int DEPTH = 1 << LINE_W;

    logic [FETCH_SIZE-1:0] mem [DEPTH];

    // Line write on the rising edge; reset wipes the whole array.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wrIdx] <= wrData;
        end
    end

    assign rdData = mem[rdIdx];

endmodule

// File: rtl/line_memory.sv
// line_memory: fixed-latency line memory on a shared 64-bit tristate bus.
// A read drives the addressed line for exactly one cycle LATENCY-2 cycles
// after the request edge; a write samples the bus LATENCY-1 edges after the
// request edge. Protocol violations are dropped and flagged on sticky err.
// Optional feature macro: LINE_MEM_STATS_EN adds rd_cnt/wr_cnt/err_cnt.
module line_memory
    import line_memory_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int ADDR_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    line_memory_if.slave          bus,
    inout  wire [FETCH_SIZE-1:0]  dataM,
    output lineMemState_t         dbgState
);

    localparam int LINE_W = ADDR_LOG2 - 2;
    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 2);

    lineMemState_t         state;
    lineMemState_t         nextState;
    logic [3:0]            waitCnt;
    logic [LINE_W-1:0]     lineIdx;
    logic [FETCH_SIZE-1:0] rdLine;
    logic                  errFlag;

    logic                  busyInt;
    logic                  drvEn;
    logic                  memWe;
    logic                  rdAccept;
    logic                  wrAccept;
    logic                  protoErr;

    // Address bits outside the line index carry no meaning here.
    logic [15:0]           unusedAddrBits;
    assign unusedAddrBits = bus.addressM;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; with LATENCY=2 the WAIT states are bypassed.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (bus.readM && !bus.writeM) begin
                    nextState = (LATENCY == 2) ? RD_DRIVE : RD_WAIT;
                end else if (bus.writeM && !bus.readM) begin
                    nextState = (LATENCY == 2) ? WR_CAPTURE : WR_WAIT;
                end
            end
            RD_WAIT:    if (waitCnt == 4'd1) nextState = RD_DRIVE;
            RD_DRIVE:   nextState = IDLE;
            WR_WAIT:    if (waitCnt == 4'd1) nextState = WR_CAPTURE;
            WR_CAPTURE: nextState = IDLE;
            default:    nextState = IDLE;
        endcase
    end

    // State-decoded outputs and request classification.
    always_comb begin
        busyInt  = (state != IDLE);
        drvEn    = (state == RD_DRIVE);
        memWe    = (state == WR_CAPTURE);
        rdAccept = (state == IDLE) && bus.readM && !bus.writeM;
        wrAccept = (state == IDLE) && bus.writeM && !bus.readM;
        protoErr = ((state != IDLE) && (bus.readM || bus.writeM)) ||
                   ((state == IDLE) && bus.readM && bus.writeM);
    end

    // WAIT down-counter: loaded on acceptance, the FSM leaves WAIT as it hits 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waitCnt <= '0;
        end else if (rdAccept || wrAccept) begin
            waitCnt <= WAIT_LOAD;
        end else if (((state == RD_WAIT) || (state == WR_WAIT)) && (waitCnt != 4'd0)) begin
            waitCnt <= waitCnt - 4'd1;
        end
    end

    // Line index is captured only on the request edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lineIdx <= '0;
        end else if (rdAccept || wrAccept) begin
            lineIdx <= bus.addressM[ADDR_LOG2-1:2];
        end
    end

    // Sticky protocol-error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            errFlag <= 1'b0;
        end else if (protoErr) begin
            errFlag <= 1'b1;
        end
    end

    line_mem_array #(
        .LINE_W (LINE_W)
    ) u_array (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (memWe),
        .wrIdx  (lineIdx),
        .wrData (dataM),
        .rdIdx  (lineIdx),
        .rdData (rdLine)
    );

    assign dataM    = drvEn ? rdLine : {FETCH_SIZE{1'bz}};
    assign bus.busy = busyInt;
    assign bus.err  = errFlag;
    assign dbgState = state;

`ifdef LINE_MEM_STATS_EN
    logic [15:0] rdCnt;
    logic [15:0] wrCnt;
    logic [15:0] errCnt;

    // Free-running wrapping event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdCnt  <= '0;
            wrCnt  <= '0;
            errCnt <= '0;
        end else begin
            if (rdAccept) rdCnt  <= rdCnt + 16'd1;
            if (memWe)    wrCnt  <= wrCnt + 16'd1;
            if (protoErr) errCnt <= errCnt + 16'd1;
        end
    end

    assign bus.rd_cnt  = rdCnt;
    assign bus.wr_cnt  = wrCnt;
    assign bus.err_cnt = errCnt;
`endif

endmodule
